// File: rtl/board_sensor_scanner.sv
`timescale 1ns/1ps
// board_sensor_scanner: continuously scans a 74HC165-style sensor chain and publishes
// a stable occupancy word with per-scan update and change strobes.
// Optional feature macro: SENSOR_DEBOUNCE_EN (multi-scan debounce; undefined = publish every scan).
module board_sensor_scanner #(
    parameter int unsigned CHAIN_BITS     = 32,
    parameter int unsigned CLK_DIV        = 50,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  sr_clk,
    output logic                  sr_load_n,
    input  logic                  sr_in,
    output logic [CHAIN_BITS-1:0] sensor_data,
    output logic                  data_valid,
    output logic                  changed
);

    localparam int unsigned PERIOD = 2 * CLK_DIV;
    localparam int unsigned DIV_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned BIT_W  = (CHAIN_BITS > 1) ? $clog2(CHAIN_BITS) : 1;

    // Marker block elaborated only for an out-of-range parameter set.
    if (CHAIN_BITS == 0 || CLK_DIV == 0 || DEBOUNCE_SCANS == 0) begin : g_illegal_params
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SHIFT  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [DIV_W-1:0]      div_cnt, div_next;
    logic [BIT_W-1:0]      bit_cnt, bit_next;
    logic [CHAIN_BITS-1:0] raw, raw_next;
    logic [CHAIN_BITS-1:0] sensor_next;
    logic                  sr_clk_next, sr_load_n_next, data_valid_next;
    logic                  publish_c, scan_done_c, period_end_c;

`ifdef SENSOR_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [CNT_W-1:0]      stable_cnt, cnt_next, cnt_upd_c;
    logic [CHAIN_BITS-1:0] prev_raw, prev_next;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counters, shift capture, debounce and registered-output next values.
    always_comb begin
        state_next      = state;
        div_next        = div_cnt;
        bit_next        = bit_cnt;
        raw_next        = raw;
        sensor_next     = sensor_data;
        publish_c       = 1'b0;
        scan_done_c     = 1'b0;
        period_end_c    = (div_cnt == DIV_W'(PERIOD - 1));
`ifdef SENSOR_DEBOUNCE_EN
        cnt_next        = stable_cnt;
        prev_next       = prev_raw;
        cnt_upd_c       = '0;
`endif

        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_next = S_LOAD;
                    div_next   = '0;
                end
            end
            S_LOAD: begin
                if (period_end_c) begin
                    state_next = S_SHIFT;
                    div_next   = '0;
                    bit_next   = '0;
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                end
            end
            S_SHIFT: begin
                // Sample on the last low-phase cycle, just before sr_clk rises.
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    raw_next = (raw << 1) | CHAIN_BITS'(sr_in);
                end
                if (period_end_c) begin
                    div_next = '0;
                    if (bit_cnt == BIT_W'(CHAIN_BITS - 1)) begin
                        state_next  = S_UPDATE;
                        scan_done_c = 1'b1;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                end
            end
            S_UPDATE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Publish decision is taken on the edge into UPDATE so it lands with data_valid.
        if (scan_done_c) begin
`ifdef SENSOR_DEBOUNCE_EN
            if (raw == prev_raw) begin
                cnt_upd_c = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
            end else begin
                cnt_upd_c = '0;
            end
            cnt_next  = cnt_upd_c;
            prev_next = raw;
            publish_c = (cnt_upd_c == CNT_MAX) && (raw != sensor_data);
`else
            publish_c = (raw != sensor_data);
`endif
            if (publish_c) begin
                sensor_next = raw;
            end
        end

        sr_clk_next     = (state_next == S_SHIFT) && (div_next >= DIV_W'(CLK_DIV));
        sr_load_n_next  = (state_next != S_LOAD);
        data_valid_next = (state_next == S_UPDATE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            raw         <= '0;
            sr_clk      <= 1'b0;
            sr_load_n   <= 1'b1;
            sensor_data <= '0;
            data_valid  <= 1'b0;
            changed     <= 1'b0;
`ifdef SENSOR_DEBOUNCE_EN
            stable_cnt  <= '0;
            prev_raw    <= '0;
`endif
        end else begin
            div_cnt     <= div_next;
            bit_cnt     <= bit_next;
            raw         <= raw_next;
            sr_clk      <= sr_clk_next;
            sr_load_n   <= sr_load_n_next;
            sensor_data <= sensor_next;
            data_valid  <= data_valid_next;
            changed     <= publish_c;
`ifdef SENSOR_DEBOUNCE_EN
            stable_cnt  <= cnt_next;
            prev_raw    <= prev_next;
`endif
        end
    end

endmodule
